uart_inst_rx: RTL and testbench

- UART 8N1 receiver on the board RsRx pin. Deserialises host-sent instruction bytes and buffers them in a small FIFO.
- Presents bytes to the sequencer core as an instruction word with a valid/ready handshake.
- This is the receive counterpart of the sequencer's RsTx SEND path. It lets a host stream {op[1:0],ra[1:0],imm/rb/rc} instructions instead of using switches plus btnS.

---
 rtl/uart_inst_rx.sv | 147 ++++++++++++++
 tb/tb_uart_inst_rx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uart_inst_rx.sv
// UART 8N1 receiver for host-streamed sequencer instructions.
// Received bytes are queued in a small FIFO and offered on a valid/ready port.
module uart_inst_rx #(
  parameter int CLKS_PER_BIT = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RsRx,
  input  logic                          inst_rdy,
  output logic [7:0]                    inst_wd,
  output logic                          inst_vld,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          frm_err,
  output logic                          ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);

  logic          rx_meta, rx_s, rx_d;
  logic [2:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic          push_req, push_ok, pop, full;

  // Synchroniser flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= RsRx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
      frm_err  <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (rx_d && !rx_s) state <= START;
        end
        START: begin
          if (baud_cnt == HALF_M1) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // Returning to IDLE at mid-stop lets a zero-gap next start edge be caught.
          if (baud_cnt == FULL_M1) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frm_err <= 1'b1;
              state   <= WAIT_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push_req = (state == STOP) && (baud_cnt == FULL_M1) && rx_s;
  assign inst_vld = (fifo_cnt != '0);
  assign full     = (fifo_cnt == FULL_CNT);
  assign pop      = inst_vld && inst_rdy;
  assign push_ok  = push_req && (!full || pop);
  assign rd_next  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  // inst_wd is a registered copy of the head so it keeps the last value when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      inst_wd  <= 8'h00;
      ovf      <= 1'b0;
    end else begin
      ovf <= push_req && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_next;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + ONE_CNT;
        2'b01:   fifo_cnt <= fifo_cnt - ONE_CNT;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (pop) begin
        if (fifo_cnt > ONE_CNT)  inst_wd <= mem[rd_next];
        else if (push_ok)        inst_wd <= shreg;
      end else if (!inst_vld && push_ok) begin
        inst_wd <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_inst_rx.sv
// Directed bench for uart_inst_rx: frames are driven bit by bit at 1 Mbaud
// and the FIFO port, pulses and timing are compared with hand-computed values.
module tb_uart_inst_rx;

  localparam int CPB = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs_rx = 1'b1;
  logic       inst_rdy = 1'b0;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic [2:0] fifo_cnt;
  logic       frm_err;
  logic       ovf;

  int total = 0;
  int bad = 0;
  int frm_seen = 0;
  int ovf_seen = 0;
  int f0, o0;

  uart_inst_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RsRx     (rs_rx),
    .inst_rdy (inst_rdy),
    .inst_wd  (inst_wd),
    .inst_vld (inst_vld),
    .fifo_cnt (fifo_cnt),
    .frm_err  (frm_err),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frm_err) frm_seen++;
    if (ovf)     ovf_seen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge that ends the last bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    rs_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs_rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    rs_rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pop_word(input string tag, input logic [7:0] exp);
    checkOutput({tag, "_vld"}, 32'(inst_vld), 32'd1);
    checkOutput({tag, "_wd"}, 32'(inst_wd), 32'(exp));
    inst_rdy = 1'b1;
    @(negedge clk);
    inst_rdy = 1'b0;
  endtask

  initial begin
    logic [7:0] burst [5];
    burst = '{8'h04, 8'h00, 8'h13, 8'h86, 8'h4B};

    repeat (3) @(negedge clk);
    checkOutput("rst_vld", 32'(inst_vld), 32'd0);
    checkOutput("rst_wd", 32'(inst_wd), 32'd0);
    checkOutput("rst_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("rst_frm", 32'(frm_err), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;

    $display("[TB] idle line");
    repeat (2000) @(negedge clk);
    checkOutput("idle_vld", 32'(inst_vld), 32'd0);
    checkOutput("idle_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("idle_pulses", 32'(frm_seen + ovf_seen), 32'd0);

    // Mid-stop sample is the 953rd rising edge after the start bit is driven.
    $display("[TB] single byte 0x13");
    fork
      send_frame(8'h13, 1'b1);
      begin
        repeat (952) @(negedge clk);
        checkOutput("lat_before", 32'(inst_vld), 32'd0);
        @(negedge clk);
        checkOutput("lat_vld", 32'(inst_vld), 32'd1);
        checkOutput("lat_wd", 32'(inst_wd), 32'h13);
        checkOutput("lat_cnt", 32'(fifo_cnt), 32'd1);
      end
    join
    inst_rdy = 1'b1;
    @(negedge clk);
    inst_rdy = 1'b0;
    checkOutput("pop1_vld", 32'(inst_vld), 32'd0);
    checkOutput("pop1_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("pop1_hold_wd", 32'(inst_wd), 32'h13);

    $display("[TB] back-to-back burst with overflow");
    o0 = ovf_seen;
    foreach (burst[i]) send_frame(burst[i], 1'b1);
    checkOutput("burst_cnt", 32'(fifo_cnt), 32'd4);
    checkOutput("burst_ovf", 32'(ovf_seen - o0), 32'd1);
    pop_word("drain0", 8'h04);
    pop_word("drain1", 8'h00);
    pop_word("drain2", 8'h13);
    pop_word("drain3", 8'h86);
    checkOutput("drain_vld", 32'(inst_vld), 32'd0);
    checkOutput("drain_cnt", 32'(fifo_cnt), 32'd0);

    $display("[TB] framing error then break");
    f0 = frm_seen;
    send_frame(8'hC0, 1'b0);
    repeat (30 * CPB) @(negedge clk);
    rs_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checkOutput("brk_frm", 32'(frm_seen - f0), 32'd1);
    checkOutput("brk_cnt", 32'(fifo_cnt), 32'd0);
    send_frame(8'hD0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("after_brk_cnt", 32'(fifo_cnt), 32'd1);
    pop_word("after_brk", 8'hD0);

    $display("[TB] start-bit glitch");
    f0 = frm_seen;
    rs_rx = 1'b0;
    repeat (30) @(negedge clk);
    rs_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("glitch_vld", 32'(inst_vld), 32'd0);
    checkOutput("glitch_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("glitch_frm", 32'(frm_seen - f0), 32'd0);

    $display("[TB] reset during data bit 4");
    send_frame(8'h21, 1'b1);
    send_frame(8'h42, 1'b1);
    checkOutput("prerst_cnt", 32'(fifo_cnt), 32'd2);
    f0 = frm_seen;
    fork
      send_frame(8'hF5, 1'b1);
      begin
        repeat (550) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_cnt", 32'(fifo_cnt), 32'd0);
        checkOutput("midrst_vld", 32'(inst_vld), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (CPB) @(negedge clk);
    checkOutput("postrst_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("postrst_frm", 32'(frm_seen - f0), 32'd0);
    send_frame(8'h5A, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("postrst_rx_cnt", 32'(fifo_cnt), 32'd1);
    pop_word("postrst_rx", 8'h5A);
    checkOutput("final_vld", 32'(inst_vld), 32'd0);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
